// File: rtl/nano_cpu.sv
// nano_cpu: minimal 16-bit accumulator-free load/store CPU.
//
// Each instruction takes two cycles: FETCH reads the instruction word at PC
// into IR, EXEC performs it. An END instruction (op F) parks the core in HALT
// until reset.
//
// Ports
//   ck       system clock, all state updates on the rising edge
//   rst      asynchronous active-high reset
//   address  memory word address (256 x 16-bit memory)
//   dataR    read data, driven combinationally by memory from address
//   dataW    write data (zero whenever no write is in progress)
//   ce       memory access enable (FETCH, READ and WRITE cycles)
//   we       write enable; memory stores dataW at address on the rising edge
module nano_cpu (
  input  logic        ck,
  input  logic        rst,
  output logic [7:0]  address,
  input  logic [15:0] dataR,
  output logic [15:0] dataW,
  output logic        ce,
  output logic        we
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;
  logic [15:0] rf [16];

  // Instruction fields. M-type r shares bits with R-type rb.
  logic [3:0]  op, rd, ra, rb;
  logic [7:0]  m_addr;
  logic [15:0] ra_val, rb_val;

  assign op     = ir_reg[15:12];
  assign rd     = ir_reg[11:8];
  assign ra     = ir_reg[7:4];
  assign rb     = ir_reg[3:0];
  assign m_addr = ir_reg[11:4];

  // Operands are taken from the current register values, so the write-back
  // at the end of EXEC never disturbs them even when rd equals ra or rb.
  assign ra_val = rf[ra];
  assign rb_val = rf[rb];

  // Register-file write port.
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [15:0] wr_data;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    wr_en      = 1'b0;
    wr_idx     = rd;
    wr_data    = 16'h0000;
    address    = pc_reg;
    ce         = 1'b0;
    we         = 1'b0;
    dataW      = 16'h0000;

    case (state_reg)
      FETCH: begin
        ce         = 1'b1;
        ir_next    = dataR;
        pc_next    = pc_reg + 8'd1;  // wraps 255 -> 0
        state_next = EXEC;
      end

      EXEC: begin
        state_next = FETCH;
        case (op)
          4'h0: begin  // READ
            address = m_addr;
            ce      = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = rb;
            wr_data = dataR;
          end
          4'h1: pc_next = m_addr;  // JMP
          4'h2: begin  // WRITE
            address = m_addr;
            ce      = 1'b1;
            we      = 1'b1;
            dataW   = rb_val;
          end
          4'h3: begin  // BRANCH if R[r] != 0
            if (rb_val != 16'h0000) pc_next = m_addr;
          end
          4'h4: begin wr_en = 1'b1; wr_data = ra_val ^ rb_val; end
          4'h5: begin wr_en = 1'b1; wr_data = ra_val & rb_val; end
          4'h6: begin wr_en = 1'b1; wr_data = ra_val + rb_val; end
          4'h7: begin wr_en = 1'b1; wr_data = {15'd0, (ra_val < rb_val)}; end
          4'h8: begin wr_en = 1'b1; wr_data = ra_val + 16'd1; end
          4'h9: begin wr_en = 1'b1; wr_data = ra_val - rb_val; end
          4'hA: begin wr_en = 1'b1; wr_data = ra_val | rb_val; end
          4'hF: state_next = HALT;  // END
          default: ;                // B..E: NOP
        endcase
      end

      HALT: state_next = HALT;

      default: state_next = FETCH;
    endcase
  end

  // Reset is asynchronous, so an in-flight WRITE loses we combinationally
  // the moment rst rises (state snaps back to FETCH).
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= 8'd0;
      ir_reg    <= 16'h0000;
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      if (wr_en) rf[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_nano_cpu.sv
// Self-checking bench for nano_cpu. A behavioural 256x16 memory answers the
// CPU; expected memory writes are queued when a program is set up and a
// monitor pops/compares them whenever the CPU asserts we.
module tb_nano_cpu;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  address;
  logic [15:0] dataR;
  logic [15:0] dataW;
  logic        ce;
  logic        we;

  always #5 ck = ~ck;

  nano_cpu dut (
    .ck      (ck),
    .rst     (rst),
    .address (address),
    .dataR   (dataR),
    .dataW   (dataW),
    .ce      (ce),
    .we      (we)
  );

  // Memory model: img is the program image prepared by the stimulus, copied
  // into mem in one cycle while the CPU is held in reset.
  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic        copy_en = 1'b0;

  always @(posedge ck) begin
    if (copy_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (we) begin
      mem[address] <= dataW;
    end
  end

  assign dataR = mem[address];

  int total  = 0;
  int passed = 0;
  int we_count   = 0;
  int fetch1_cnt = 0;
  int fetch4_cnt = 0;

  // Expected writes: {addr[7:0], data[15:0]}
  logic [23:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe is one transaction.
  always @(negedge ck) begin
    if (!rst && we) begin
      logic [23:0] e;
      we_count++;
      $display("write addr=%h data=%h", address, dataW);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", address, dataW);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {24'd0, address}, {24'd0, e[23:16]});
        chk("write_data", {16'd0, dataW}, {16'd0, e[15:0]});
      end
    end
  end

  // Instruction fetch observer for the loop test (FETCH cycles of address 1/4).
  always @(negedge ck) begin
    if (!rst && ce && !we) begin
      if (address == 8'd1) fetch1_cnt++;
      if (address == 8'd4) fetch4_cnt++;
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge ck);
    @(negedge ck);
  endtask

  // Hold rst for two rising edges (loading memory meanwhile), then release.
  task automatic start_prog();
    @(negedge ck);
    rst = 1'b1;
    copy_en = 1'b1;
    @(posedge ck);
    @(negedge ck);
    copy_en = 1'b0;
    @(posedge ck);
    @(negedge ck);
    chk("rst_address", {24'd0, address}, 32'd0);
    chk("rst_ce", {31'd0, ce}, 32'd1);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_dataW", {16'd0, dataW}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_address", {24'd0, address}, 32'd0);
    chk("post_rst_ce", {31'd0, ce}, 32'd1);
    chk("post_rst_we", {31'd0, we}, 32'd0);
  endtask

  initial begin
    int base_we, base_f1, base_f4;

    // ---------------- Memory path ----------------
    clear_img();
    img[0]  = 16'h01E3;  // READ  R3 <= mem[0x1E]
    img[1]  = 16'h2283;  // WRITE mem[0x28] <= R3
    img[2]  = 16'hF000;
    img[30] = 16'h0006;
    exp_q.push_back({8'h28, 16'h0006});
    start_prog();
    base_we = we_count;
    cycles(1);
    chk("mem_ir_after_fetch", {16'd0, dut.ir_reg}, 32'h01E3);
    chk("mem_pc_after_fetch", {24'd0, dut.pc_reg}, 32'd1);
    chk("mem_read_address", {24'd0, address}, 32'h1E);
    chk("mem_read_ce", {31'd0, ce}, 32'd1);
    cycles(3);
    chk("mem40", {16'd0, mem[40]}, 32'h0006);
    chk("mem_we_cycles", we_count - base_we, 32'd1);

    // ---------------- ALU path ----------------
    clear_img();
    img[0] = 16'h4000;  // R0 = R0^R0 = 0
    img[1] = 16'h8100;  // R1 = R0+1 = 1
    img[2] = 16'h6211;  // R2 = R1+R1 = 2
    img[3] = 16'h7320;  // R3 = (R2 < R0) = (2 < 0) = 0
    img[4] = 16'h9402;  // R4 = R0-R2 = FFFE
    img[5] = 16'h2505;  // mem[0x50] = R5 = 0
    img[6] = 16'hF000;
    img[8'h50] = 16'h1234;
    exp_q.push_back({8'h50, 16'h0000});
    start_prog();
    cycles(14);
    chk("alu_r1", {16'd0, dut.rf[1]}, 32'h0001);
    chk("alu_r2", {16'd0, dut.rf[2]}, 32'h0002);
    chk("alu_r3", {16'd0, dut.rf[3]}, 32'h0000);
    chk("alu_r4", {16'd0, dut.rf[4]}, 32'hFFFE);
    chk("alu_mem50", {16'd0, mem[8'h50]}, 32'h0000);
    for (int i = 0; i < 5; i++) begin
      chk("halt_address", {24'd0, address}, 32'd7);
      chk("halt_ce", {31'd0, ce}, 32'd0);
      chk("halt_we", {31'd0, we}, 32'd0);
      chk("halt_dataW", {16'd0, dataW}, 32'd0);
      cycles(1);
    end

    // ---------------- Logic ops, rd==ra, NOP ----------------
    clear_img();
    img[0]  = 16'h0F01;  // R1 = F0F0
    img[1]  = 16'h0F12;  // R2 = 3C3C
    img[2]  = 16'h5312;  // R3 = AND = 3030
    img[3]  = 16'hA412;  // R4 = OR  = FCFC
    img[4]  = 16'h4512;  // R5 = XOR = CCCC
    img[5]  = 16'h7621;  // R6 = (3C3C < F0F0) = 1
    img[6]  = 16'h9112;  // R1 = F0F0-3C3C = B4B4
    img[7]  = 16'hB000;  // NOP
    img[8]  = 16'h2E03;
    img[9]  = 16'h2E14;
    img[10] = 16'h2E25;
    img[11] = 16'h2E36;
    img[12] = 16'h2E41;
    img[13] = 16'hF000;
    img[8'hF0] = 16'hF0F0;
    img[8'hF1] = 16'h3C3C;
    exp_q.push_back({8'hE0, 16'h3030});
    exp_q.push_back({8'hE1, 16'hFCFC});
    exp_q.push_back({8'hE2, 16'hCCCC});
    exp_q.push_back({8'hE3, 16'h0001});
    exp_q.push_back({8'hE4, 16'hB4B4});
    start_prog();
    cycles(30);
    chk("logic_halt_address", {24'd0, address}, 32'd14);

    // ---------------- Loop: count to 6 ----------------
    clear_img();
    img[0] = 16'h0F02;  // R2 = mem[0xF0] = 6
    img[1] = 16'h8000;  // R0 = R0+1
    img[2] = 16'h7302;  // R3 = R0 < R2
    img[3] = 16'h3013;  // if R3 != 0 goto 1
    img[4] = 16'h2F10;  // mem[0xF1] = R0
    img[5] = 16'hF000;
    img[8'hF0] = 16'h0006;
    exp_q.push_back({8'hF1, 16'h0006});
    start_prog();
    base_f1 = fetch1_cnt;
    base_f4 = fetch4_cnt;
    // 21 instructions: END is fetched in cycle 40.
    cycles(40);
    chk("loop_end_fetch_address", {24'd0, address}, 32'd5);
    chk("loop_end_fetch_ce", {31'd0, ce}, 32'd1);
    cycles(2);
    chk("loop_halt_address", {24'd0, address}, 32'd6);
    chk("loop_halt_ce", {31'd0, ce}, 32'd0);
    chk("loop_taken", fetch1_cnt - base_f1 - 1, 32'd5);
    chk("loop_not_taken", fetch4_cnt - base_f4, 32'd1);

    // ---------------- Wrap ----------------
    clear_img();
    img[0]     = 16'h3F01;  // if R1 != 0 goto F0 (not taken first time)
    img[1]     = 16'h1FF0;  // JMP FF
    img[8'hFF] = 16'h0FE1;  // R1 = mem[0xFE] = FFFF, then PC wraps to 0
    img[8'hFE] = 16'hFFFF;
    img[8'hF0] = 16'h8211;  // R2 = R1+1 = 0000
    img[8'hF1] = 16'h2E02;  // mem[0xE0] = R2
    img[8'hF2] = 16'h2E11;  // mem[0xE1] = R1
    img[8'hF3] = 16'hF000;
    exp_q.push_back({8'hE0, 16'h0000});
    exp_q.push_back({8'hE1, 16'hFFFF});
    start_prog();
    cycles(6);
    chk("wrap_fetch_address", {24'd0, address}, 32'd0);
    chk("wrap_fetch_ce", {31'd0, ce}, 32'd1);
    cycles(14);
    chk("wrap_halt_address", {24'd0, address}, 32'hF4);

    // ---------------- Reset during WRITE ----------------
    clear_img();
    img[0]     = 16'h2283;  // mem[0x28] = R3 (= 0)
    img[1]     = 16'hF000;
    img[8'h28] = 16'hABCD;
    start_prog();
    @(posedge ck);
    #1;
    chk("midw_we_before", {31'd0, we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midw_we_dropped", {31'd0, we}, 32'd0);
    chk("midw_address", {24'd0, address}, 32'd0);
    chk("midw_ce", {31'd0, ce}, 32'd1);
    @(posedge ck);
    @(posedge ck);
    @(negedge ck);
    chk("midw_mem_unchanged", {16'd0, mem[8'h28]}, 32'hABCD);
    exp_q.push_back({8'h28, 16'h0000});
    rst = 1'b0;
    cycles(1);
    chk("midw_restart_ir", {16'd0, dut.ir_reg}, 32'h2283);
    cycles(1);
    chk("midw_mem_after", {16'd0, mem[8'h28]}, 32'h0000);
    cycles(3);
    chk("midw_halt_address", {24'd0, address}, 32'd2);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
